id_stage: RTL and testbench

- Fetch-sequencing and decode stage of the 8-bit pipelined processor; sits directly upstream of the ID/WB pipeline register.
- Holds the program counter, the IF/ID instruction register, the 8x8 register file and a write-first bypass from the writeback stage.
- Decodes the held instruction and presents data_a, data_b, rdst, imm_data and status combinationally to the ID/WB register inputs.

---
 rtl/id_stage.sv | 131 +++++++++++++
 tb/tb_id_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Fetch sequencing, IF/ID instruction register, 8x8 register file with a
// write-first bypass from writeback, and decode for the 8-bit pipeline.
module id_stage #(
   parameter int unsigned PC_W    = 8,
   parameter logic [7:0]  REG_RST = 8'h00
) (
   input  logic            clk,
   input  logic            reset,
   output logic [PC_W-1:0] pc,
   input  logic [7:0]      instr_in,
   input  logic            wb_en,
   input  logic [2:0]      wb_addr,
   input  logic [7:0]      wb_data,
   output logic [7:0]      data_a,
   output logic [7:0]      data_b,
   output logic [2:0]      rdst,
   output logic [2:0]      imm_data,
   output logic            status,
   output logic            halted
);

   localparam int unsigned DW   = 8;
   localparam int unsigned AW   = 3;
   localparam int unsigned NREG = 8;

   localparam logic [1:0]    OP_MOVI   = 2'b00;
   localparam logic [1:0]    OP_ADD    = 2'b01;
   localparam logic [1:0]    OP_HALT   = 2'b11;
   localparam logic [DW-1:0] INSTR_NOP = 8'h80;

   logic [DW-1:0]   ifid;
   logic [DW-1:0]   ifid_nxt;
   logic [PC_W-1:0] pc_nxt;
   logic            halted_nxt;
   logic            stop;

   logic [DW-1:0]   rf [NREG];

   logic [DW-1:0]   dec_instr;
   logic [1:0]      opcode;
   logic [AW-1:0]   addr_a;
   logic [AW-1:0]   addr_b;

   // Next fetch state: a HALT in ID or a halted core freezes pc and feeds NOPs
   always_comb begin
      stop       = halted || (ifid[7:6] == OP_HALT);
      pc_nxt     = pc;
      ifid_nxt   = INSTR_NOP;
      halted_nxt = halted;
      if (reset) begin
         pc_nxt     = '0;
         ifid_nxt   = INSTR_NOP;
         halted_nxt = 1'b0;
      end else begin
         halted_nxt = stop;
         if (!stop) begin
            pc_nxt   = pc + PC_W'(1);
            ifid_nxt = instr_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      pc     <= pc_nxt;
      ifid   <= ifid_nxt;
      halted <= halted_nxt;
   end

   // Register file; r0 is held at zero and never written
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (i == 0) begin
            rf[i] <= '0;
         end else if (reset) begin
            rf[i] <= REG_RST;
         end else if (wb_en && (wb_addr == AW'(i))) begin
            rf[i] <= wb_data;
         end
      end
   end

   // While in reset the decode sees a NOP regardless of what ifid holds
   assign dec_instr = reset ? INSTR_NOP : ifid;
   assign opcode    = dec_instr[7:6];
   assign addr_a    = dec_instr[5:3];
   assign addr_b    = dec_instr[2:0];

   // Read port A with write-first bypass
   always_comb begin
      data_a = rf[addr_a];
      if (addr_a == '0) begin
         data_a = '0;
      end else if (wb_en && (wb_addr == addr_a)) begin
         data_a = wb_data;
      end
   end

   // Read port B with write-first bypass
   always_comb begin
      data_b = rf[addr_b];
      if (addr_b == '0) begin
         data_b = '0;
      end else if (wb_en && (wb_addr == addr_b)) begin
         data_b = wb_data;
      end
   end

   // NOP and HALT present a write of zero to r0, which WB discards
   always_comb begin
      rdst     = '0;
      imm_data = '0;
      status   = 1'b0;
      case (opcode)
         OP_MOVI: begin
            rdst     = addr_a;
            imm_data = addr_b;
         end
         OP_ADD: begin
            rdst     = addr_a;
            imm_data = addr_b;
            status   = 1'b1;
         end
         default: begin
            rdst     = '0;
            imm_data = '0;
            status   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: an ISA-level model predicts each cycle's
// decode outputs; a negedge monitor pops and compares them.
module tb_id_stage;

   localparam logic [7:0] RST_VAL = 8'h3C;

   typedef struct packed {
      logic [7:0] pc;
      logic       halted;
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] rdst;
      logic [2:0] imm;
      logic       status;
      logic [2:0] pc3;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       rst3;
   logic [7:0] pc;
   logic [7:0] instr_in;
   logic       wb_en;
   logic [2:0] wb_addr;
   logic [7:0] wb_data;
   logic [7:0] data_a;
   logic [7:0] data_b;
   logic [2:0] rdst;
   logic [2:0] imm_data;
   logic       status;
   logic       halted;

   logic [2:0] pc3;
   logic [7:0] a3;
   logic [7:0] b3;
   logic [2:0] rdst3;
   logic [2:0] imm3;
   logic       status3;
   logic       halted3;

   logic [7:0] imem [256];

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model state
   bit         known = 1'b0;
   logic [7:0] mpc;
   logic [7:0] mid;
   bit         mhalt;
   logic [7:0] R [8];
   logic [2:0] pend_addr;
   logic [7:0] pend_data;
   logic [2:0] m3;
   bit         tog3 = 1'b1;

   always #5 clk = ~clk;

   assign instr_in = imem[pc];

   id_stage #(.PC_W(8), .REG_RST(RST_VAL)) dut (
      .clk      (clk),
      .reset    (reset),
      .pc       (pc),
      .instr_in (instr_in),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .data_a   (data_a),
      .data_b   (data_b),
      .rdst     (rdst),
      .imm_data (imm_data),
      .status   (status),
      .halted   (halted)
   );

   id_stage #(.PC_W(3), .REG_RST(8'hA5)) dut3 (
      .clk      (clk),
      .reset    (rst3),
      .pc       (pc3),
      .instr_in (8'h80),
      .wb_en    (1'b0),
      .wb_addr  (3'd0),
      .wb_data  (8'd0),
      .data_a   (a3),
      .data_b   (b3),
      .rdst     (rdst3),
      .imm_data (imm3),
      .status   (status3),
      .halted   (halted3)
   );

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp_v, $time);
      end
   endtask

   task automatic fill_nop();
      for (int i = 0; i < 256; i++) imem[i] = 8'h80;
   endtask

   // One clock: drive inputs, predict outputs, then advance the model past the edge
   task automatic cycle(input bit rst, input bit inj, input logic [2:0] ia, input logic [7:0] idat);
      exp_t       e;
      logic [7:0] rn [8];
      logic [7:0] d;
      logic [1:0] op;
      bit         m3_at5;
      reset = rst;
      if (rst) begin
         wb_en   = 1'($urandom);
         wb_addr = 3'($urandom);
         wb_data = 8'($urandom);
      end else begin
         wb_en = 1'b1;
         if (inj && pend_addr == 3'd0) begin
            wb_addr = ia;
            wb_data = idat;
         end else begin
            wb_addr = pend_addr;
            wb_data = pend_data;
         end
      end
      m3_at5 = known && (m3 == 3'd5);
      rst3   = rst || (m3_at5 && tog3);

      rn = R;
      if (!rst && wb_en && wb_addr != 3'd0) rn[wb_addr] = wb_data;
      rn[0] = 8'h00;
      d = rst ? 8'h80 : mid;
      if (known) begin
         e.pc     = mpc;
         e.halted = mhalt;
         e.pc3    = m3;
         e.rdst   = 3'd0;
         e.imm    = 3'd0;
         e.status = 1'b0;
         if (d[7] == 1'b0) begin
            e.rdst   = d[5:3];
            e.imm    = d[2:0];
            e.status = d[6];
         end
         e.a = rn[d[5:3]];
         e.b = rn[d[2:0]];
         q.push_back(e);
      end

      @(posedge clk);

      if (rst3) m3 = 3'd0;
      else m3 = m3 + 3'd1;
      if (m3_at5) tog3 = ~tog3;

      if (rst) begin
         mpc   = 8'h00;
         mid   = 8'h80;
         mhalt = 1'b0;
         R[0]  = 8'h00;
         for (int r = 1; r < 8; r++) R[r] = RST_VAL;
         pend_addr = 3'd0;
         pend_data = 8'($urandom);
         known = 1'b1;
      end else begin
         R  = rn;
         op = mid[7:6];
         if (op == 2'd0) begin
            pend_addr = mid[5:3];
            pend_data = {5'd0, mid[2:0]};
         end else if (op == 2'd1) begin
            pend_addr = mid[5:3];
            pend_data = rn[mid[5:3]] + rn[mid[2:0]];
         end else begin
            pend_addr = 3'd0;
            pend_data = 8'($urandom);
         end
         if (op == 2'd3 || mhalt) begin
            mhalt = 1'b1;
            mid   = 8'h80;
         end else begin
            mid = imem[mpc];
            mpc = mpc + 8'd1;
         end
      end
      #1;
   endtask

   // Monitor: compare whatever the model predicted for this cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc", pc, e.pc);
            chk("halted", 8'(halted), 8'(e.halted));
            chk("data_a", data_a, e.a);
            chk("data_b", data_b, e.b);
            chk("rdst", 8'(rdst), 8'(e.rdst));
            chk("imm_data", 8'(imm_data), 8'(e.imm));
            chk("status", 8'(status), 8'(e.status));
            chk("pc3", 8'(pc3), 8'(e.pc3));
            chk("halted3", 8'(halted3), 8'h00);
         end
      end
   end

   initial begin
      logic [7:0] b;
      int         r;
      reset   = 1'b1;
      rst3    = 1'b1;
      wb_en   = 1'b0;
      wb_addr = 3'd0;
      wb_data = 8'd0;

      // MOVI/ADD with bypass, r0 protection
      fill_nop();
      imem[0] = 8'h0D; imem[1] = 8'h13; imem[2] = 8'h4A; imem[3] = 8'h07;
      imem[4] = 8'h48; imem[5] = 8'h80; imem[6] = 8'h48; imem[7] = 8'h51;
      cycle(1, 0, 3'd0, 8'd0);
      cycle(1, 0, 3'd0, 8'd0);
      for (int i = 0; i < 14; i++) cycle(0, 0, 3'd0, 8'd0);

      // HALT at address 3, then restart after reset
      fill_nop();
      imem[0] = 8'h0D; imem[1] = 8'h13; imem[2] = 8'h4A; imem[3] = 8'hC0;
      imem[4] = 8'h0F; imem[5] = 8'h11;
      cycle(1, 0, 3'd0, 8'd0);
      for (int i = 0; i < 12; i++) cycle(0, 1, 3'd6, 8'(i));
      cycle(1, 0, 3'd0, 8'd0);
      for (int i = 0; i < 6; i++) cycle(0, 0, 3'd0, 8'd0);

      // ADD overflow: r1 = FF injected, r2 = 2, then read the wrapped sum
      fill_nop();
      imem[0] = 8'h12; imem[1] = 8'h4A; imem[2] = 8'h59;
      cycle(1, 0, 3'd0, 8'd0);
      cycle(0, 1, 3'd1, 8'hFF);
      for (int i = 0; i < 8; i++) cycle(0, 0, 3'd0, 8'd0);

      // Random programs, random WB injections, occasional mid-run reset
      for (int round = 0; round < 40; round++) begin
         for (int i = 0; i < 256; i++) begin
            r = $urandom_range(0, 15);
            b = 8'($urandom);
            if (r == 0) imem[i] = {2'b11, b[5:0]};
            else if (r < 3) imem[i] = {2'b10, b[5:0]};
            else imem[i] = {1'b0, b[6:0]};
         end
         for (int i = 0; i < $urandom_range(1, 2); i++) cycle(1, 0, 3'd0, 8'd0);
         for (int i = 0; i < 50; i++)
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                  3'($urandom), 8'($urandom));
      end

      @(negedge clk);
      #1;
      chk("queue_drain", 8'(q.size()), 8'h00);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
